pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised fetch-stage program-counter generator. Holds the architectural fetch PC and selects the next PC from, in priority order: reset, trap, redirect, stall hold, and sequential/predicted advance. An optional direct-mapped branch target buffer (BTB) predicts taken branches. Sits at the head of the fetch stage, feeding instruction memory, and takes stall/redirect from hazard logic and BTB training from execute.

## Interface
- `XLEN`, 32: PC width in bits.
- `RESET_VEC`, 0: PC value loaded by reset.
- `TRAP_VEC`, 32'h0000_0100: PC value loaded on `trap_valid`.
- `INST_BYTES`, 4: sequential increment; power of 2, minimum 2.
- `BTB_DEPTH`, 16: BTB entries; power of 2, minimum 2. Ignored without `PC_BTB_EN`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `stall`  in  1  data-hazard hold.
- `redirect_valid`  in  1  control-hazard redirect.
- `redirect_pc`  in  XLEN  redirect target.
- `trap_valid`  in  1  exception/trap entry.
- `upd_valid`  in  1  BTB training strobe from execute.
- `upd_pc`  in  XLEN  PC of the resolved branch.
- `upd_target`  in  XLEN  resolved target.
- `upd_taken`  in  1  branch resolved taken.
- `pc`  out  XLEN  current fetch PC, registered.
- `pc_valid`  out  1  `pc` is fetchable, registered.
- `pred_taken`  out  1  BTB hit on current `pc`, combinational.
- `npc`  out  XLEN  value `pc` loads at next edge if unstalled, combinational.

## Operation
- Next-PC priority per rising edge:
  - `rst`=0: `pc`←`RESET_VEC`, `pc_valid`←0.
  - `trap_valid`: `pc`←`TRAP_VEC`.
  - `redirect_valid`: `pc`←`redirect_pc`.
  - `stall`: `pc` holds.
  - Otherwise: `pc`←`npc`.
- Trap and redirect override stall. Trap beats redirect when both are asserted in the same cycle.
- After reset releases, `pc_valid`←1 at the first edge and stays 1 until the next reset.
- `npc` = BTB target on a hit, else `pc + INST_BYTES`.
- All sums wrap modulo 2^XLEN; 0xFFFF_FFFC + 4 = 0.
- The low log2(`INST_BYTES`) bits of `redirect_pc`, `upd_target` and `pc` are forced to zero.
- BTB is direct-mapped:
  - Index = `pc[log2(INST_BYTES)+log2(BTB_DEPTH)-1 : log2(INST_BYTES)]`.
  - Tag = remaining upper bits.
  - Each entry holds a valid bit, tag and target.
  - Hit = valid and tag equal. `pred_taken` = hit.
- BTB update on the `upd_valid` edge:
  - `upd_taken`=1: write valid, tag and target at the `upd_pc` index. This overwrites any alias.
  - `upd_taken`=0 with tag match: clear valid.
  - `upd_taken`=0 with tag mismatch: no change.
- BTB update happens irrespective of stall, trap or redirect.
- Reset clears every BTB valid bit. Tags and targets need no reset.

## Timing
- Reset values: `pc`=`RESET_VEC`, `pc_valid`=0, `pred_taken`=0, `npc`=`RESET_VEC`+`INST_BYTES`. No BTB hit is possible because all entries are invalid.
- Latency:
  - Redirect or trap asserted in cycle N: `pc` shows the new target in cycle N+1.
  - Stall asserted in cycle N: `pc` in N+1 equals `pc` in N.
- BTB lookup is read-before-write. An update in cycle N is visible to lookups from cycle N+1.
- Reset mid-operation: any cycle with `rst`=0 discards pending redirect, trap and stall, and clears the BTB at that edge.
- No handshakes. All inputs are single-cycle level-sampled.

## Configuration
- `PC_BTB_EN` defined: BTB storage and lookup are built as described.
- `PC_BTB_EN` undefined:
  - No BTB storage.
  - `pred_taken` is tied 0.
  - `npc` = `pc + INST_BYTES`.
  - `upd_*` inputs are ignored.

## Structure
- Shared package `pc_pkg`:
  - `XLEN` default.
  - Reset and trap vector constants.
  - `btb_entry_t` struct (valid, tag, target).
  - Index/tag width functions derived from `BTB_DEPTH` and `INST_BYTES`.
- One sub-module, `pc_btb`: BTB storage, lookup and update. Instantiated only under `PC_BTB_EN`.
- `pc_gen` keeps the PC register and priority mux.

## Test plan
- Reset, then release with no stall: `pc` = 0, 4, 8, 12 on successive cycles; `pc_valid` is 0 during reset and 1 from the first released edge.
- `stall`=1 for 3 cycles at `pc`=8: `pc` holds 8; it resumes at 12 when stall drops.
- `stall`=1 and `redirect_valid`=1 with `redirect_pc`=0x40 in the same cycle: next `pc`=0x40. Adding `trap_valid` in the same cycle gives next `pc`=0x100.
- `redirect_pc`=0x4A: `pc`=0x48. `redirect_pc`=0xFFFF_FFFC unstalled: next `pc`=0.
- `PC_BTB_EN`, `BTB_DEPTH`=16:
  - Train `upd_pc`=0x20, `upd_target`=0x80, taken.
  - Next visit to 0x20: `pred_taken`=1, `npc`=0x80.
  - `upd_pc`=0x60 taken (same index) evicts the entry: at 0x20, `pred_taken`=0.
  - `upd_pc`=0x20 with `upd_taken`=0 after retraining: entry is invalidated.
- Mid-run reset after BTB training: `pc`=0 and no BTB hits on retrace.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage PC generator.
// Optional BTB is enabled with the PC_BTB_EN macro.
package pc_pkg;

    localparam int PC_XLEN = 32;

    localparam logic [PC_XLEN-1:0] PC_RESET_VEC = 32'h0000_0000;
    localparam logic [PC_XLEN-1:0] PC_TRAP_VEC  = 32'h0000_0100;

    // Tag is kept zero-extended to the full PC width.
    typedef struct packed {
        logic               valid;
        logic [PC_XLEN-1:0] tag;
        logic [PC_XLEN-1:0] target;
    } btb_entry_t;

    function automatic int off_w(input int inst_bytes);
        return $clog2(inst_bytes);
    endfunction

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int tag_w(input int xlen,
                                 input int inst_bytes,
                                 input int depth);
        return xlen - off_w(inst_bytes) - idx_w(depth);
    endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: lookup on the fetch PC,
// training from execute. Built only when PC_BTB_EN is defined.
module pc_btb
    import pc_pkg::*;
#(
    parameter int XLEN       = PC_XLEN,
    parameter int INST_BYTES = 4,
    parameter int BTB_DEPTH  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            hit,
    output logic [XLEN-1:0] target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken
);

    localparam int OW = off_w(INST_BYTES);
    localparam int IW = idx_w(BTB_DEPTH);

    localparam logic [XLEN-1:0] ALIGN = ~XLEN'(INST_BYTES - 1);

    btb_entry_t mem [BTB_DEPTH];

    logic [IW-1:0]      rd_idx;
    logic [IW-1:0]      wr_idx;
    logic [PC_XLEN-1:0] rd_tag;
    logic [PC_XLEN-1:0] wr_tag;
    btb_entry_t         rd;

    assign rd_idx = IW'(pc >> OW);
    assign wr_idx = IW'(upd_pc >> OW);
    assign rd_tag = PC_XLEN'(pc >> (OW + IW));
    assign wr_tag = PC_XLEN'(upd_pc >> (OW + IW));

    // Read-before-write: lookups see the array as of the last edge.
    assign rd     = mem[rd_idx];
    assign hit    = rd.valid && (rd.tag == rd_tag);
    assign target = XLEN'(rd.target);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                mem[i].valid <= 1'b0;
            end
        end else if (upd_valid) begin
            if (upd_taken) begin
                mem[wr_idx] <= '{
                    valid:  1'b1,
                    tag:    wr_tag,
                    target: PC_XLEN'(upd_target & ALIGN)
                };
            end else if (mem[wr_idx].tag == wr_tag) begin
                mem[wr_idx].valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC register and next-PC priority mux.
// Define PC_BTB_EN to build the branch target buffer.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN       = PC_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC  = PC_RESET_VEC,
    parameter logic [XLEN-1:0] TRAP_VEC   = PC_TRAP_VEC,
    parameter int              INST_BYTES = 4,
    parameter int              BTB_DEPTH  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            pred_taken,
    output logic [XLEN-1:0] npc
);

    localparam logic [XLEN-1:0] ALIGN = ~XLEN'(INST_BYTES - 1);

    logic [XLEN-1:0] seq_pc;
    logic            btb_hit;
    logic [XLEN-1:0] btb_target;

    assign seq_pc = pc + XLEN'(INST_BYTES);

`ifdef PC_BTB_EN
    pc_btb #(
        .XLEN       (XLEN),
        .INST_BYTES (INST_BYTES),
        .BTB_DEPTH  (BTB_DEPTH)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .hit        (btb_hit),
        .target     (btb_target),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken)
    );
`else
    logic unused_upd;

    assign unused_upd = ^{upd_valid, upd_pc, upd_target, upd_taken};
    assign btb_hit    = 1'b0;
    assign btb_target = '0;
`endif

    assign pred_taken = btb_hit;
    assign npc        = btb_hit ? btb_target : seq_pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc       <= RESET_VEC & ALIGN;
            pc_valid <= 1'b0;
        end else begin
            pc_valid <= 1'b1;
            // Trap and redirect both win over a hazard stall.
            if (trap_valid) begin
                pc <= TRAP_VEC & ALIGN;
            end else if (redirect_valid) begin
                pc <= redirect_pc & ALIGN;
            end else if (!stall) begin
                pc <= npc;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: vector table plus BTB sequences.
// BTB expectations follow the PC_BTB_EN build macro.
module tb_pc_gen;

`ifdef PC_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pred_taken;
    logic [31:0] npc;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        pred;
        logic [31:0] npc;
    } exp_t;

    typedef struct {
        logic        r;
        logic        s;
        logic        rv;
        logic [31:0] rpc;
        logic        tr;
        logic [31:0] epc;
        logic        ev;
    } vec_t;

    exp_t sb[$];

    pc_gen dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .pred_taken     (pred_taken),
        .npc            (npc)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        chk32({tag, ".pc"}, pc, e.pc);
        chk32({tag, ".pc_valid"}, 32'(pc_valid), 32'(e.valid));
        chk32({tag, ".pred_taken"}, 32'(pred_taken), 32'(e.pred));
        chk32({tag, ".npc"}, npc, e.npc);
    endtask

    // Drive one cycle of stimulus, queue what the edge should produce,
    // then compare #1 after the edge.
    task automatic cyc(input string tag,
                       input logic r, input logic s,
                       input logic rv, input logic [31:0] rp,
                       input logic tr,
                       input logic uv, input logic [31:0] up,
                       input logic [31:0] ut, input logic utk,
                       input logic [31:0] e_pc, input logic e_v,
                       input logic e_pred, input logic [31:0] e_npc);
        exp_t e;
        rst            = r;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rp;
        trap_valid     = tr;
        upd_valid      = uv;
        upd_pc         = up;
        upd_target     = ut;
        upd_taken      = utk;
        e.pc    = e_pc;
        e.valid = e_v;
        e.pred  = e_pred;
        e.npc   = e_npc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    vec_t vt[17];

    initial begin
        rst            = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        trap_valid     = 1'b0;
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_target     = '0;
        upd_taken      = 1'b0;

        //          r     s     rv    rpc            tr    epc            ev
        vt[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h4,        1'b1};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h8,        1'b1};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h8,        1'b1};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h8,        1'b1};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h8,        1'b1};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'hC,        1'b1};
        vt[8]  = '{1'b1, 1'b1, 1'b1, 32'h40,       1'b0, 32'h40,       1'b1};
        vt[9]  = '{1'b1, 1'b1, 1'b1, 32'h40,       1'b1, 32'h100,      1'b1};
        vt[10] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h104,      1'b1};
        vt[11] = '{1'b1, 1'b0, 1'b1, 32'h4A,       1'b0, 32'h48,       1'b1};
        vt[12] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b1};
        vt[13] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
        vt[14] = '{1'b1, 1'b0, 1'b1, 32'h200,      1'b1, 32'h100,      1'b1};
        vt[15] = '{1'b0, 1'b1, 1'b1, 32'h200,      1'b1, 32'h0,        1'b0};
        vt[16] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h4,        1'b1};

        for (int i = 0; i < 17; i++) begin
            cyc($sformatf("vec%0d", i),
                vt[i].r, vt[i].s, vt[i].rv, vt[i].rpc, vt[i].tr,
                1'b0, 32'h0, 32'h0, 1'b0,
                vt[i].epc, vt[i].ev, 1'b0, vt[i].epc + 32'd4);
        end

        // Train 0x20 -> 0x80 while redirecting to 0x1C.
        cyc("train", 1, 0, 1, 32'h1C, 0, 1, 32'h20, 32'h80, 1,
            32'h1C, 1, 0, 32'h20);
        cyc("hit20", 1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0,
            32'h20, 1, BTB, BTB ? 32'h80 : 32'h24);
        cyc("follow", 1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0,
            BTB ? 32'h80 : 32'h24, 1, 0, BTB ? 32'h84 : 32'h28);

        // Alias at 0x60 evicts the 0x20 entry.
        cyc("evict", 1, 0, 1, 32'h20, 0, 1, 32'h60, 32'h200, 1,
            32'h20, 1, 0, 32'h24);
        cyc("retrain", 1, 1, 1, 32'h20, 0, 1, 32'h20, 32'h80, 1,
            32'h20, 1, BTB, BTB ? 32'h80 : 32'h24);
        // Not-taken with mismatching tag leaves the entry alone.
        cyc("nt_alias", 1, 1, 0, 32'h0, 0, 1, 32'h60, 32'h0, 0,
            32'h20, 1, BTB, BTB ? 32'h80 : 32'h24);
        cyc("nt_clear", 1, 1, 0, 32'h0, 0, 1, 32'h20, 32'h0, 0,
            32'h20, 1, 0, 32'h24);

        // Retrain, then reset mid-run must wipe the BTB.
        cyc("retrain2", 1, 1, 0, 32'h0, 0, 1, 32'h20, 32'h80, 1,
            32'h20, 1, BTB, BTB ? 32'h80 : 32'h24);
        cyc("midrst", 0, 0, 1, 32'h20, 1, 0, 32'h0, 32'h0, 0,
            32'h0, 0, 0, 32'h4);
        cyc("retrace", 1, 0, 1, 32'h20, 0, 0, 32'h0, 32'h0, 0,
            32'h20, 1, 0, 32'h24);
        cyc("retrace2", 1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0,
            32'h24, 1, 0, 32'h28);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain actual=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
